// File: rtl/conv1x1_pkg.sv
// Shared constants and helpers for the conv1x1 issue controller.
//   CONV_WIDTH   : default operand width; results are twice as wide.
//   CORE_LATENCY : cycles from core_valid_in to core_valid_out of the core.
//   res_width()  : result width derived from the operand width.
//   has_credit() : true while the result FIFO can absorb one more issue.
package conv1x1_pkg;

  localparam int unsigned CONV_WIDTH   = 16;
  localparam int unsigned CORE_LATENCY = 2;

  function automatic int unsigned res_width(input int unsigned w);
    return 2 * w;
  endfunction

  // Every issued op owns a FIFO slot from issue until it is popped, so the
  // free credit is whatever the queued and in-flight results leave over.
  function automatic logic has_credit(input int unsigned depth,
                                      input int unsigned fifo_count,
                                      input int unsigned inflight);
    return (fifo_count + inflight) < depth;
  endfunction

endpackage

// File: rtl/conv1x1_result_fifo.sv
// Result FIFO for the conv1x1 issue controller.
//   clk, rst_n : clock, synchronous active-low reset (pointers and count only)
//   wr_en      : push wr_data at the tail
//   rd_en      : pop the head; ignored when empty
//   rd_data    : head entry, read straight from registered storage
//   count      : number of stored entries (0..DEPTH)
module conv1x1_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_rd;
  logic             w_do_wr;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_do_rd = rd_en & ~w_empty;
  // A write into a full FIFO is still legal when the head leaves on the same edge.
  assign w_do_wr = wr_en & (~w_full | w_do_rd);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_wr && !w_do_rd)      r_count <= r_count + CW'(1);
      else if (!w_do_wr && w_do_rd) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/conv1x1_issue_ctrl.sv
// Credit-based issue controller in front of a 2-stage conv1x1 core.
//   s_valid/s_ready/s_x,s_w,s_b : operand triple handshake from upstream
//   core_valid_in, core_x/w/b   : issue strobe and operands to the core
//   core_valid_out, core_y      : result returning from the core
//   m_valid/m_ready/m_y         : result stream to downstream, in issue order
//   inflight                    : issued ops whose result has not returned yet
//   err_unexpected              : sticky, a result returned with nothing in flight
module conv1x1_issue_ctrl
  import conv1x1_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [WIDTH-1:0]                s_x,
  input  logic [WIDTH-1:0]                s_w,
  input  logic [WIDTH-1:0]                s_b,
  output logic                            core_valid_in,
  output logic [WIDTH-1:0]                core_x,
  output logic [WIDTH-1:0]                core_w,
  output logic [WIDTH-1:0]                core_b,
  input  logic [res_width(WIDTH)-1:0]     core_y,
  input  logic                            core_valid_out,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [res_width(WIDTH)-1:0]     m_y,
  output logic [$clog2(DEPTH+1)-1:0]      inflight,
  output logic                            err_unexpected
);

  localparam int RES_W = res_width(WIDTH);
  localparam int CW    = $clog2(DEPTH+1);

  // Below CORE_LATENCY+1 entries the credit loop cannot sustain one result per cycle.
  if (DEPTH < int'(CORE_LATENCY) + 1) begin : g_depth_check
    $error("conv1x1_issue_ctrl: DEPTH too small for the core latency");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_pow2_check
    $error("conv1x1_issue_ctrl: DEPTH must be a power of two");
  end

  logic [CW-1:0] r_inflight;
  logic          r_err;
  logic [CW-1:0] w_fifo_count;
  logic          w_credit;
  logic          w_issue;
  logic          w_ret;
  logic          w_spur;
  logic          w_pop;

  // Credit comes from registered counts only, so s_ready never depends on s_valid.
  assign w_credit = has_credit(DEPTH, 32'(w_fifo_count), 32'(r_inflight));
  assign s_ready  = rst_n & w_credit;

  assign w_issue       = s_valid & s_ready;
  assign core_valid_in = w_issue;
  assign core_x        = s_x;
  assign core_w        = s_w;
  assign core_b        = s_b;

  // A return with nothing outstanding is dropped and only flagged.
  assign w_ret  = core_valid_out & (r_inflight != '0);
  assign w_spur = core_valid_out & (r_inflight == '0);

  assign m_valid = rst_n & (w_fifo_count != '0);
  assign w_pop   = m_valid & m_ready;

  assign inflight       = rst_n ? r_inflight : '0;
  assign err_unexpected = rst_n & r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_issue && !w_ret)      r_inflight <= r_inflight + CW'(1);
      else if (!w_issue && w_ret) r_inflight <= r_inflight - CW'(1);
      if (w_spur) r_err <= 1'b1;
    end
  end

  conv1x1_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_ret),
    .wr_data (core_y),
    .rd_en   (w_pop),
    .rd_data (m_y),
    .count   (w_fifo_count)
  );

endmodule
